// File: rtl/motor_start_sequencer_if.sv
// -----------------------------------------------------------------------------
// motor_start_sequencer_if
//
// Groups the control and status signals of the motor start sequencer.
//   master : drives enable, potensio_value, HallA/B/C, fault_in and observes
//            duty, force_en, force_step, state, running, fault_code.
//   slave  : the sequencer itself (mirror image of master).
//
// Parameter DWIDTH sets the width of potensio_value and duty. It must match
// the DWIDTH of the sequencer it is connected to.
// -----------------------------------------------------------------------------
interface motor_start_sequencer_if #(
  parameter int DWIDTH = 10
);
  logic              enable;
  logic [DWIDTH-1:0] potensio_value;
  logic              HallA;
  logic              HallB;
  logic              HallC;
  logic              fault_in;
  logic [DWIDTH-1:0] duty;
  logic              force_en;
  logic [2:0]        force_step;
  logic [2:0]        state;
  logic              running;
  logic [1:0]        fault_code;

  modport master (
    output enable, potensio_value, HallA, HallB, HallC, fault_in,
    input  duty, force_en, force_step, state, running, fault_code
  );

  modport slave (
    input  enable, potensio_value, HallA, HallB, HallC, fault_in,
    output duty, force_en, force_step, state, running, fault_code
  );
endinterface

// File: rtl/motor_start_sequencer.sv
// -----------------------------------------------------------------------------
// motor_start_sequencer
//
// Start-up sequencer for a hall-sensed BLDC motor: IDLE -> ALIGN (forced step 0
// at a fixed duty) -> RAMP (duty slews up one LSB per step period) -> RUN
// (duty tracks potensio_value one LSB per step period). Any fault parks the
// block in a sticky FAULT state with a cause code.
//
// Ports
//   clk   : system clock (single domain)
//   rst   : asynchronous, active-high reset
//   bus   : motor_start_sequencer_if.slave
//           in : enable, potensio_value, HallA/B/C (asynchronous), fault_in
//           out: duty, force_en, force_step, state, running, fault_code
//
// Parameters
//   DWIDTH, ALIGN_DUTY, ALIGN_CYCLES, STEP_CYCLES, STALL_CYCLES
//
// Configuration
//   STALL_DETECT_EN : when defined, a hall-idle counter faults the block with
//                     code 3 after STALL_CYCLES cycles without a hall change
//                     in RAMP or RUN. When undefined no stall logic is built.
// -----------------------------------------------------------------------------
module motor_start_sequencer #(
  parameter int DWIDTH       = 10,
  parameter int ALIGN_DUTY   = 64,
  parameter int ALIGN_CYCLES = 1000000,
  parameter int STEP_CYCLES  = 5000,
  parameter int STALL_CYCLES = 5000000
) (
  input  logic                   clk,
  input  logic                   rst,
  motor_start_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_RAMP  = 3'd2,
    S_RUN   = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    FC_NONE  = 2'd0,
    FC_EXT   = 2'd1,
    FC_HALL  = 2'd2,
    FC_STALL = 2'd3
  } fault_t;

  // One shared phase counter serves both the align timer and the slew timer,
  // so it is sized for the longer of the two.
  localparam int CNT_MAX = (ALIGN_CYCLES > STEP_CYCLES) ? ALIGN_CYCLES : STEP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // Reject degenerate timing configurations at elaboration.
  if (ALIGN_CYCLES < 1 || STEP_CYCLES < 1 || STALL_CYCLES < 1) begin : g_bad_cfg
    $error("motor_start_sequencer: cycle parameters must be >= 1");
  end

  logic [2:0]        hall_s1;
  logic [2:0]        hall_s2;
  state_t            state_q;
  state_t            next_state;
  fault_t            fault_q;
  fault_t            fault_next;
  logic [DWIDTH-1:0] duty_q;
  logic [DWIDTH-1:0] duty_next;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_next;
  logic              in_drive;
  logic              hall_bad;
  logic              stall_hit;
  logic              step_tick;
  logic              align_done;

  // ---------------------------------------------------------------------------
  // Hall synchronizer: two flops, all decisions use hall_s2.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse the
  // two synchronizer stages into one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hall_s1 <= '0;
      hall_s2 <= '0;
    end else begin
      hall_s1 <= {bus.HallA, bus.HallB, bus.HallC};
      hall_s2 <= hall_s1;
    end
  end

  assign in_drive   = (state_q == S_RAMP) || (state_q == S_RUN);
  assign hall_bad   = in_drive && ((hall_s2 == 3'b000) || (hall_s2 == 3'b111));
  assign step_tick  = (cnt_q == CNT_W'(STEP_CYCLES - 1));
  assign align_done = (cnt_q == CNT_W'(ALIGN_CYCLES - 1));

  // ---------------------------------------------------------------------------
  // Optional stall detector
  // ---------------------------------------------------------------------------
`ifdef STALL_DETECT_EN
  localparam int STALL_W = $clog2(STALL_CYCLES + 1);

  logic [2:0]         hall_q;
  logic [STALL_W-1:0] stall_cnt_q;
  logic               hall_changed;

  assign hall_changed = (hall_s2 != hall_q);
  assign stall_hit    = in_drive && !hall_changed &&
                        (stall_cnt_q == STALL_W'(STALL_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hall_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      hall_q <= hall_s2;
      if ((next_state != state_q) || !in_drive || hall_changed)
        stall_cnt_q <= '0;
      else
        stall_cnt_q <= stall_cnt_q + STALL_W'(1);
    end
  end
`else
  assign stall_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= next_state;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state and fault-cause logic, in priority order
  // ---------------------------------------------------------------------------
  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    next_state = state_q;
    fault_next = fault_q;
    if (bus.fault_in) begin
      next_state = S_FAULT;
      fault_next = FC_EXT;
    end else if (hall_bad) begin
      next_state = S_FAULT;
      fault_next = FC_HALL;
    end else if (stall_hit) begin
      next_state = S_FAULT;
      fault_next = FC_STALL;
    end else if (!bus.enable && ((state_q == S_ALIGN) || in_drive)) begin
      next_state = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  if (bus.enable) next_state = S_ALIGN;
        S_ALIGN: if (align_done) next_state = S_RAMP;
        S_RAMP: begin
          // Target at or below the current duty: snap to it. Otherwise leave
          // on the step that lands exactly on the target.
          if (bus.potensio_value <= duty_q)
            next_state = S_RUN;
          else if (step_tick && (bus.potensio_value == duty_q + DWIDTH'(1)))
            next_state = S_RUN;
        end
        S_RUN:   ;
        S_FAULT: begin
          if (!bus.enable) begin
            next_state = S_IDLE;
            fault_next = FC_NONE;
          end
        end
        default: next_state = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Duty and phase-counter datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    duty_next = duty_q;
    if ((next_state == S_IDLE) || (next_state == S_FAULT)) begin
      duty_next = '0;
    end else begin
      case (state_q)
        S_IDLE: duty_next = DWIDTH'(ALIGN_DUTY);
        S_RAMP: begin
          if (bus.potensio_value <= duty_q) duty_next = bus.potensio_value;
          else if (step_tick)               duty_next = duty_q + DWIDTH'(1);
        end
        S_RUN: begin
          // Stepping only toward the target keeps duty inside its range.
          if (step_tick) begin
            if (bus.potensio_value > duty_q)      duty_next = duty_q + DWIDTH'(1);
            else if (bus.potensio_value < duty_q) duty_next = duty_q - DWIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cnt_next = '0;
    if (next_state != state_q)     cnt_next = '0;  // restart on every entry
    else if (in_drive && step_tick) cnt_next = '0;
    else if ((state_q == S_ALIGN) || in_drive) cnt_next = cnt_q + CNT_W'(1);
  end

  // NOTE: every register, counter included, is cleared by the asynchronous
  // reset so that no duty or timing survives an aborted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_q  <= '0;
      cnt_q   <= '0;
      fault_q <= FC_NONE;
    end else begin
      duty_q  <= duty_next;
      cnt_q   <= cnt_next;
      fault_q <= fault_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.force_en   = (state_q == S_ALIGN);
    bus.force_step = 3'd0;
    bus.running    = (state_q == S_RUN);
  end

  assign bus.state      = state_q;
  assign bus.duty       = duty_q;
  assign bus.fault_code = fault_q;

endmodule

// File: tb/tb_motor_start_sequencer.sv
// -----------------------------------------------------------------------------
// tb_motor_start_sequencer
//
// Drives motor_start_sequencer through its interface with short timing
// parameters and compares every sampled output against a behavioural model
// that tracks time spent in each mode and applies the sequencing rules
// directly. Scenario tasks add directed checks on top.
// -----------------------------------------------------------------------------
module tb_motor_start_sequencer;

  localparam int DW  = 10;
  localparam int AC  = 16;
  localparam int SC  = 4;
  localparam int AD  = 64;
  localparam int STC = 100;

  localparam int M_IDLE = 0, M_ALIGN = 1, M_RAMP = 2, M_RUN = 3, M_FAULT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  motor_start_sequencer_if #(.DWIDTH(DW)) bus ();

  motor_start_sequencer #(
    .DWIDTH       (DW),
    .ALIGN_DUTY   (AD),
    .ALIGN_CYCLES (AC),
    .STEP_CYCLES  (SC),
    .STALL_CYCLES (STC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  bit spin  = 1'b0;

  // ---------------------------------------------------------------------------
  // Reference model: mode, duty, cause code, cycles spent in the current mode
  // and cycles the synchronized hall value has been unchanged.
  // ---------------------------------------------------------------------------
  int         m_state, m_duty, m_fc, m_phase, m_same;
  logic [2:0] h_old, h_new, h_prev;

  always @(posedge clk or posedge rst) begin : model_p
    int         ns, nd, nfc;
    logic [2:0] hs;
    logic       chg, in_rr, stall;
    if (rst) begin
      m_state <= M_IDLE; m_duty <= 0; m_fc <= 0; m_phase <= 0; m_same <= 0;
      h_old <= 3'd0; h_new <= 3'd0; h_prev <= 3'd0;
    end else begin
      hs    = h_old;  // hall value seen two edges ago
      chg   = (hs != h_prev);
      in_rr = (m_state == M_RAMP) || (m_state == M_RUN);
`ifdef STALL_DETECT_EN
      stall = in_rr && !chg && (m_same == STC - 1);
`else
      stall = 1'b0;
`endif
      ns = m_state; nd = m_duty; nfc = m_fc;
      if (bus.fault_in) begin
        ns = M_FAULT; nfc = 1; nd = 0;
      end else if (in_rr && (hs == 3'b000 || hs == 3'b111)) begin
        ns = M_FAULT; nfc = 2; nd = 0;
      end else if (stall) begin
        ns = M_FAULT; nfc = 3; nd = 0;
      end else if (!bus.enable && (m_state == M_ALIGN || in_rr)) begin
        ns = M_IDLE; nd = 0;
      end else begin
        case (m_state)
          M_IDLE:  if (bus.enable) begin ns = M_ALIGN; nd = AD; end
          M_ALIGN: if (m_phase + 1 == AC) ns = M_RAMP;
          M_RAMP: begin
            if (int'(bus.potensio_value) <= m_duty) begin
              nd = bus.potensio_value; ns = M_RUN;
            end else if ((m_phase + 1) % SC == 0) begin
              nd = m_duty + 1;
              if (nd == int'(bus.potensio_value)) ns = M_RUN;
            end
          end
          M_RUN: begin
            if ((m_phase + 1) % SC == 0) begin
              if (int'(bus.potensio_value) > m_duty)      nd = m_duty + 1;
              else if (int'(bus.potensio_value) < m_duty) nd = m_duty - 1;
            end
          end
          M_FAULT: if (!bus.enable) begin ns = M_IDLE; nfc = 0; nd = 0; end
          default: ;
        endcase
      end
      h_old   <= h_new;
      h_new   <= {bus.HallA, bus.HallB, bus.HallC};
      h_prev  <= hs;
      m_phase <= (ns != m_state) ? 0 : m_phase + 1;
      m_same  <= (ns != m_state || chg) ? 0 : m_same + 1;
      m_state <= ns;
      m_duty  <= nd;
      m_fc    <= nfc;
    end
  end

  function automatic logic [19:0] dut_vec();
    return {bus.state, bus.duty, bus.force_en, bus.force_step, bus.running, bus.fault_code};
  endfunction

  function automatic logic [19:0] model_vec();
    return {3'(m_state), 10'(m_duty), (m_state == M_ALIGN), 3'd0, (m_state == M_RUN), 2'(m_fc)};
  endfunction

  // Rotating valid hall pattern while spin is set.
  initial begin
    forever begin
      @(negedge clk);
      if (spin) {bus.HallA, bus.HallB, bus.HallC} = 3'($urandom_range(1, 6));
    end
  end

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    bus.enable = 1'b0; bus.potensio_value = '0; bus.fault_in = 1'b0;
    {bus.HallA, bus.HallB, bus.HallC} = 3'b000;
    repeat (2) @(negedge clk);
    total++;
    if (dut_vec() !== 20'h0) begin
      bad++; $display("FAIL reset_outputs: got %h want %h", dut_vec(), 20'h0);
    end
    total++;
    if (dut_vec() !== model_vec()) begin
      bad++; $display("FAIL reset_model: got %h want %h", dut_vec(), model_vec());
    end
    rst = 1'b0;
    spin = 1'b1;
  endtask

  task automatic test_startup();
    int align_n = 0, ramp_n = 0, first_ramp = -1, last_ramp = -1;
    bit done = 1'b0;
    bus.potensio_value = 10'd70;
    bus.enable = 1'b1;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++; $display("FAIL startup_trace c=%0d: got %h want %h", c, dut_vec(), model_vec());
      end
      if (bus.state == 3'd1) align_n++;
      if (bus.state == 3'd2) begin
        ramp_n++;
        if (first_ramp < 0) first_ramp = int'(bus.duty);
        last_ramp = int'(bus.duty);
      end
      if (bus.state == 3'd3) done = 1'b1;
    end
    total++;
    if (!done) begin bad++; $display("FAIL startup_timeout: state=%0d want 3", bus.state); end
    total++;
    if (align_n != AC) begin bad++; $display("FAIL align_len: got %0d want %0d", align_n, AC); end
    total++;
    if (ramp_n != 6 * SC) begin bad++; $display("FAIL ramp_len: got %0d want %0d", ramp_n, 6 * SC); end
    total++;
    if (first_ramp != AD || last_ramp != 69) begin
      bad++; $display("FAIL ramp_duty: got %0d..%0d want 64..69", first_ramp, last_ramp);
    end
    total++;
    if (bus.running !== 1'b1 || bus.duty !== 10'd70) begin
      bad++; $display("FAIL run_entry: got running=%b duty=%0d want 1/70", bus.running, bus.duty);
    end
  endtask

  task automatic test_low_target();
    int t9 = -1, t8 = -1;
    bit in_ramp = 1'b0;
    bus.enable = 1'b0;
    @(negedge clk);
    total++;
    if (dut_vec() !== model_vec()) begin
      bad++; $display("FAIL low_disable: got %h want %h", dut_vec(), model_vec());
    end
    bus.enable = 1'b1;
    bus.potensio_value = 10'd200;
    for (int c = 0; c < 40 && !in_ramp; c++) begin
      @(negedge clk);
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++; $display("FAIL low_trace c=%0d: got %h want %h", c, dut_vec(), model_vec());
      end
      in_ramp = (bus.state == 3'd2);
    end
    total++;
    if (!in_ramp) begin bad++; $display("FAIL low_ramp_timeout: state=%0d want 2", bus.state); end
    repeat (5) @(negedge clk);
    bus.potensio_value = 10'd10;
    @(negedge clk);
    total++;
    if (bus.duty !== 10'd10 || bus.state !== 3'd3) begin
      bad++; $display("FAIL low_snap: got duty=%0d state=%0d want 10/3", bus.duty, bus.state);
    end
    bus.potensio_value = 10'd8;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++; $display("FAIL low_step c=%0d: got %h want %h", c, dut_vec(), model_vec());
      end
      if (bus.duty == 10'd9 && t9 < 0) t9 = c;
      if (bus.duty == 10'd8 && t8 < 0) t8 = c;
    end
    total++;
    if (t9 != SC - 1 || t8 != 2 * SC - 1) begin
      bad++; $display("FAIL low_step_times: got %0d,%0d want %0d,%0d", t9, t8, SC - 1, 2 * SC - 1);
    end
  endtask

  task automatic test_fault();
    bus.fault_in = 1'b1;
    @(negedge clk);
    bus.fault_in = 1'b0;
    total++;
    if (bus.state !== 3'd4 || bus.duty !== '0 || bus.fault_code !== 2'd1 || bus.force_en !== 1'b0) begin
      bad++; $display("FAIL fault_entry: got state=%0d duty=%0d code=%0d fe=%b want 4/0/1/0",
                      bus.state, bus.duty, bus.fault_code, bus.force_en);
    end
    repeat (4) begin
      @(negedge clk);
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++; $display("FAIL fault_hold: got %h want %h", dut_vec(), model_vec());
      end
    end
    total++;
    if (bus.state !== 3'd4 || bus.fault_code !== 2'd1) begin
      bad++; $display("FAIL fault_sticky: got state=%0d code=%0d want 4/1", bus.state, bus.fault_code);
    end
    bus.enable = 1'b0;
    @(negedge clk);
    total++;
    if (bus.state !== 3'd0 || bus.fault_code !== 2'd0) begin
      bad++; $display("FAIL fault_exit: got state=%0d code=%0d want 0/0", bus.state, bus.fault_code);
    end
  endtask

  task automatic test_invalid_hall();
    int n = 0;
    bit in_run = 1'b0;
    bus.potensio_value = 10'($urandom_range(65, 72));
    bus.enable = 1'b1;
    for (int c = 0; c < 80 && !in_run; c++) begin
      @(negedge clk);
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++; $display("FAIL hall_trace c=%0d: got %h want %h", c, dut_vec(), model_vec());
      end
      in_run = (bus.state == 3'd3);
    end
    total++;
    if (!in_run) begin bad++; $display("FAIL hall_run_timeout: state=%0d want 3", bus.state); end
    spin = 1'b0;
    @(negedge clk);
    {bus.HallA, bus.HallB, bus.HallC} = 3'b111;
    while (n < 8 && bus.state != 3'd4) begin
      @(negedge clk);
      n++;
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++; $display("FAIL hall_wait n=%0d: got %h want %h", n, dut_vec(), model_vec());
      end
    end
    total++;
    if (n != 3 || bus.fault_code !== 2'd2) begin
      bad++; $display("FAIL hall_invalid: got edges=%0d code=%0d want 3/2", n, bus.fault_code);
    end
    bus.enable = 1'b0;
    @(negedge clk);
    total++;
    if (bus.state !== 3'd0) begin bad++; $display("FAIL hall_exit: got state=%0d want 0", bus.state); end
  endtask

  task automatic test_stall();
    bit in_run = 1'b0;
    spin = 1'b1;
    bus.potensio_value = 10'd66;
    bus.enable = 1'b1;
    for (int c = 0; c < 80 && !in_run; c++) begin
      @(negedge clk);
      in_run = (bus.state == 3'd3);
    end
    total++;
    if (!in_run) begin bad++; $display("FAIL stall_run_timeout: state=%0d want 3", bus.state); end
    spin = 1'b0;
    @(negedge clk);
    {bus.HallA, bus.HallB, bus.HallC} = 3'b101;
    for (int c = 0; c < 130; c++) begin
      @(negedge clk);
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++; $display("FAIL stall_trace c=%0d: got %h want %h", c, dut_vec(), model_vec());
      end
    end
`ifdef STALL_DETECT_EN
    total++;
    if (bus.state !== 3'd4 || bus.fault_code !== 2'd3) begin
      bad++; $display("FAIL stall_result: got state=%0d code=%0d want 4/3", bus.state, bus.fault_code);
    end
`else
    total++;
    if (bus.state !== 3'd3 || bus.fault_code !== 2'd0) begin
      bad++; $display("FAIL stall_result: got state=%0d code=%0d want 3/0", bus.state, bus.fault_code);
    end
`endif
  endtask

  task automatic test_random();
    spin = 1'b1;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++; $display("FAIL random c=%0d: got %h want %h", c, dut_vec(), model_vec());
      end
      bus.fault_in = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 39) == 0) bus.enable = ~bus.enable;
      if ($urandom_range(0, 29) == 0) bus.potensio_value = 10'($urandom_range(0, 120));
    end
    bus.fault_in = 1'b0;
  endtask

  task automatic test_reset_mid_ramp();
    bit found = 1'b0;
    bus.fault_in = 1'b0;
    bus.enable = 1'b0;
    spin = 1'b1;
    repeat (2) @(negedge clk);
    bus.enable = 1'b1;
    bus.potensio_value = 10'd100;
    for (int c = 0; c < 120 && !found; c++) begin
      @(negedge clk);
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++; $display("FAIL midramp_trace c=%0d: got %h want %h", c, dut_vec(), model_vec());
      end
      found = (bus.state == 3'd2) && (bus.duty == 10'd67);
    end
    total++;
    if (!found) begin bad++; $display("FAIL midramp_timeout: duty=%0d want 67", bus.duty); end
    #2 rst = 1'b1;
    #1;
    total++;
    if (bus.duty !== '0 || bus.state !== 3'd0) begin
      bad++; $display("FAIL async_reset: got duty=%0d state=%0d want 0/0", bus.duty, bus.state);
    end
    total++;
    if (bus.running !== 1'b0 || bus.force_en !== 1'b0 || bus.fault_code !== 2'd0) begin
      bad++; $display("FAIL async_reset_flags: got run=%b fe=%b code=%0d want 0/0/0",
                      bus.running, bus.force_en, bus.fault_code);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.state !== 3'd1 || bus.duty !== 10'(AD)) begin
      bad++; $display("FAIL restart_align: got state=%0d duty=%0d want 1/%0d", bus.state, bus.duty, AD);
    end
    total++;
    if (dut_vec() !== model_vec()) begin
      bad++; $display("FAIL restart_model: got %h want %h", dut_vec(), model_vec());
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_low_target();
    test_fault();
    test_invalid_hall();
    test_stall();
    test_random();
    test_reset_mid_ramp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/motor_start_sequencer.md
MOTOR_START_SEQUENCER -- requirements
Module: motor_start_sequencer

Interface
REQ-001 Parameter DWIDTH, 10: duty and potensio_value width.
REQ-002 Parameter ALIGN_DUTY, 64: fixed duty applied during rotor alignment.
REQ-003 Parameter ALIGN_CYCLES, 1000000: clk cycles spent in ALIGN.
REQ-004 Parameter STEP_CYCLES, 5000: clk cycles per single-LSB duty slew step.
REQ-005 Parameter STALL_CYCLES, 5000000: hall-idle timeout, used only with the stall option.
REQ-006 clk  in  1  system clock; the block uses a single clock domain.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 enable  in  1  run request, level-sensitive.
REQ-009 potensio_value  in  DWIDTH  target duty.
REQ-010 HallA, HallB, HallC  in  1 each  raw hall sensor inputs, asynchronous to clk.
REQ-011 fault_in  in  1  external overcurrent fault, active-high.
REQ-012 duty  out  DWIDTH  duty command to the PWM generators.
REQ-013 force_en  out  1  when 1, commutation is overridden by force_step.
REQ-014 force_step  out  3  forced commutation step; the only value used is 0.
REQ-015 state  out  3  encoding: IDLE=0, ALIGN=1, RAMP=2, RUN=3, FAULT=4.
REQ-016 running  out  1  high only in RUN.
REQ-017 fault_code  out  2  encoding: 0 none, 1 external, 2 invalid hall, 3 stall.

Function
REQ-018 Hall inputs SHALL pass through a 2-flop synchronizer; all hall decisions use the synchronized value, giving 2 cycles of latency.
REQ-019 IDLE: duty=0, force_en=0. When enable=1 and fault_in=0, the block SHALL move to ALIGN on the next edge.
REQ-020 ALIGN: force_en=1, force_step=0, duty=ALIGN_DUTY. After exactly ALIGN_CYCLES cycles in ALIGN, the block SHALL move to RAMP.
REQ-021 RAMP: force_en=0 and duty starts at ALIGN_DUTY. Duty SHALL increase by 1 every STEP_CYCLES cycles until duty equals potensio_value, then move to RUN.
REQ-022 RAMP: if potensio_value <= duty, duty SHALL be loaded with potensio_value and the block SHALL move to RUN on the same edge.
REQ-023 RUN: every STEP_CYCLES cycles, duty SHALL step by +1 or -1 toward potensio_value, and hold when equal. Duty SHALL stay within 0..2^DWIDTH-1 with no wrap.
REQ-024 The slew counter SHALL restart on every state entry.
REQ-025 enable=0 in ALIGN, RAMP or RUN: the next state SHALL be IDLE, with duty=0 on that edge.
REQ-026 fault_in=1 in any state: the next state SHALL be FAULT, with fault_code=1 and duty=0 and force_en=0 on that edge.
REQ-027 Synchronized hall value 000 or 111 in RAMP or RUN: the next state SHALL be FAULT with fault_code=2.
REQ-028 When several conditions coincide, priority SHALL be: fault_in, then invalid hall, then stall, then enable=0, then normal progression.
REQ-029 FAULT is sticky. The block SHALL leave FAULT for IDLE only when enable=0 and fault_in=0; fault_code clears on that transition.

Reset
REQ-030 rst=1 SHALL force state=IDLE, duty=0, force_en=0, force_step=0, running=0, fault_code=0, clear all counters, and clear the synchronizers, without waiting for a clock edge.
REQ-031 Reset asserted mid-ramp SHALL abort the ramp. After release, no stored duty SHALL survive, and the block SHALL restart from IDLE.

Configuration
REQ-032 With macro STALL_DETECT_EN defined: in RAMP or RUN, if the synchronized hall value is unchanged for STALL_CYCLES consecutive cycles, the next state SHALL be FAULT with fault_code=3. The stall counter resets on every hall change and on state entry.
REQ-033 With STALL_DETECT_EN undefined: no stall counter is built, and fault_code=3 is never produced.

Verification
REQ-034 Bench parameters: ALIGN_CYCLES=16, STEP_CYCLES=4, ALIGN_DUTY=64, STALL_CYCLES=100.
REQ-035 Startup: enable=1, potensio_value=70, valid halls -> ALIGN for 16 cycles; RAMP with duty 64, 65 … 70 at 4-cycle intervals; then RUN with running=1.
REQ-036 Low target: in RAMP, set potensio_value=10 -> duty=10 and RUN on the same edge; later, potensio_value=8 -> duty 9, then 8, at 4-cycle intervals.
REQ-037 Fault while running: fault_in pulsed for 1 cycle in RUN -> FAULT, duty=0, fault_code=1 held. enable=0 -> IDLE on the next edge.
REQ-038 Invalid hall: halls=111 in RUN -> FAULT with fault_code=2, 3 edges later (2 synchronizer edges plus 1 transition edge).
REQ-039 Stall: with STALL_DETECT_EN, halls frozen in RUN for 100 cycles -> fault_code=3. Without the macro, the same stimulus stays in RUN.
REQ-040 Reset mid-ramp: rst asserted with duty=67 -> duty=0 and state=0 asynchronously. With enable still 1 after release -> ALIGN on the next edge.
